sram_controller: RTL and testbench

Parametrised external-SRAM access controller for the THCO-MIPS memory stage. It replaces the clock-level-driven RAM control with a single-edge, registered state machine. The machine uses a req/ready/done handshake, programmable wait states, a write data-hold phase and a high-Z bus turnaround. It sits between the MEM stage (or bus arbiter) and the board SRAM pins, and keeps the shared-bus UART read strobe deasserted.

---
 rtl/sram_controller.sv | 131 +++++++++++++
 tb/tb_sram_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Registered external-SRAM access controller: req/ready/done handshake,
// programmable strobe length, write data hold and high-Z bus turnaround.
module sram_controller #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic                  ready_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  ram_en_out,
    output logic                  ram_oe_out,
    output logic                  ram_we_out,
    output logic [ADDR_WIDTH-1:0] ram_address_out,
    inout  wire  [DATA_WIDTH-1:0] ram_data_inout,
    output logic                  ram_rdn_out
);

    // Strobe length clamped to at least one cycle.
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES < 1) ? 32'd1 : $unsigned(WAIT_CYCLES);
    localparam int unsigned CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  drive_q, drive_d;
    logic                  en_d, oe_d, we_d, done_d, ready_d;

    // The UART shares the data bus; its read strobe is parked inactive.
    assign ram_rdn_out = 1'b1;

    // Data bus is driven only while a write transaction is in flight.
    assign ram_data_inout = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    // Next state plus next pin values, derived from the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = ram_address_out;
        wdata_d = wdata_q;
        rdata_d = rdata_out;

        case (state_q)
            S_IDLE: begin
                if (req_in) begin
                    state_d = S_SETUP;
                    wr_d    = we_in;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RECOVER;
                    if (!wr_q) begin
                        rdata_d = ram_data_inout;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        en_d    = (state_d == S_IDLE);
        oe_d    = !((state_d == S_ACCESS) && !wr_d);
        we_d    = !((state_d == S_ACCESS) && wr_d);
        drive_d = (state_d != S_IDLE) && wr_d;
        done_d  = (state_d == S_RECOVER);
        ready_d = (state_d == S_IDLE);
    end

    // State, latched request and all pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wr_q            <= 1'b0;
            wdata_q         <= '0;
            drive_q         <= 1'b0;
            ram_address_out <= '0;
            rdata_out       <= '0;
            ram_en_out      <= 1'b1;
            ram_oe_out      <= 1'b1;
            ram_we_out      <= 1'b1;
            done_out        <= 1'b0;
            ready_out       <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_q            <= wr_d;
            wdata_q         <= wdata_d;
            drive_q         <= drive_d;
            ram_address_out <= addr_d;
            rdata_out       <= rdata_d;
            ram_en_out      <= en_d;
            ram_oe_out      <= oe_d;
            ram_we_out      <= we_d;
            done_out        <= done_d;
            ready_out       <= ready_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (1 and 3 wait cycles), each on
// its own SRAM model; table vectors, corner sequences and random traffic.
module tb_sram_controller;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b1;

    logic [1:0] req = '0, we = '0;
    logic [1:0][AW-1:0] addr = '0;
    logic [1:0][DW-1:0] wdata = '0;
    logic [1:0] ready, done, en, oe, wen, rdn;
    logic [1:0][AW-1:0] raddr;
    logic [1:0][DW-1:0] rdata;
    wire  [DW-1:0] bus0, bus1;

    logic [DW-1:0] sram0 [0:(1<<AW)-1];
    logic [DW-1:0] sram1 [0:(1<<AW)-1];
    logic          pre_go = 1'b0;
    int            pre_i = 0;
    logic [AW-1:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;

    int n_vec = 0;
    int n_mis = 0;
    string ctx = "init";
    logic [1:0][DW-1:0] last_rd = '0;

    always #5 if (clk_run) clk = ~clk;

    sram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst), .req_in(req[0]), .we_in(we[0]), .addr_in(addr[0]),
        .wdata_in(wdata[0]), .ready_out(ready[0]), .done_out(done[0]),
        .rdata_out(rdata[0]), .ram_en_out(en[0]), .ram_oe_out(oe[0]),
        .ram_we_out(wen[0]), .ram_address_out(raddr[0]),
        .ram_data_inout(bus0), .ram_rdn_out(rdn[0]));

    sram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst), .req_in(req[1]), .we_in(we[1]), .addr_in(addr[1]),
        .wdata_in(wdata[1]), .ready_out(ready[1]), .done_out(done[1]),
        .rdata_out(rdata[1]), .ram_en_out(en[1]), .ram_oe_out(oe[1]),
        .ram_we_out(wen[1]), .ram_address_out(raddr[1]),
        .ram_data_inout(bus1), .ram_rdn_out(rdn[1]));

    // Asynchronous SRAM: drives the bus while selected with output enable low.
    assign bus0 = (!en[0] && !oe[0]) ? sram0[raddr[0]] : {DW{1'bz}};
    assign bus1 = (!en[1] && !oe[1]) ? sram1[raddr[1]] : {DW{1'bz}};

    // SRAM array updates: bench preloads, and bus contents while we is low.
    always @(negedge clk) begin
        if (pre_go) begin
            if (pre_i == 0) sram0[pre_a] <= pre_d;
            else            sram1[pre_a] <= pre_d;
        end
        if (!en[0] && !wen[0]) sram0[raddr[0]] <= bus0;
        if (!en[1] && !wen[1]) sram1[raddr[1]] <= bus1;
    end

    function automatic int wcy(input int i);
        return (i != 0) ? W1 : W0;
    endfunction

    function automatic logic drv(input int i);
        return (i != 0) ? dut1.drive_q : dut0.drive_q;
    endfunction

    function automatic logic [DW-1:0] bus_val(input int i);
        return (i != 0) ? bus1 : bus0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s %s: got %0h expected %0h", ctx, nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_i = i; pre_a = a; pre_d = d; pre_go = 1'b1;
        @(negedge clk);
        #1;
        pre_go = 1'b0;
    endtask

    task automatic reset_chk(input int i);
        chk("rst_en",    32'(en[i]),    32'd1);
        chk("rst_oe",    32'(oe[i]),    32'd1);
        chk("rst_we",    32'(wen[i]),   32'd1);
        chk("rst_rdn",   32'(rdn[i]),   32'd1);
        chk("rst_done",  32'(done[i]),  32'd0);
        chk("rst_addr",  32'(raddr[i]), 32'd0);
        chk("rst_rdata", 32'(rdata[i]), 32'd0);
        chk("rst_drive", 32'(drv(i)),   32'd0);
    endtask

    // One transaction, observed cycle by cycle from the accept edge.
    // mode 0: plain; 1: spurious request during ACCESS; 2: hold a read of next_a.
    task automatic run_txn(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                           input int mode, input logic [AW-1:0] next_a);
        int wc;
        int k;
        int bad_addr, bad_bus, bad_rd;
        logic [15:0] t_en, t_oe, t_we, t_done, t_rdy, t_drv;
        logic [15:0] e_en, e_oe, e_we, e_done, e_rdy, e_drv;
        logic [DW-1:0] prev;
        wc = wcy(i);
        prev = last_rd[i];
        k = 0;
        while (!ready[i] && k < 20) begin
            step();
            k++;
        end
        if (!ready[i]) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        step();
        bad_addr = 0; bad_bus = 0; bad_rd = 0;
        t_en = '0; t_oe = '0; t_we = '0; t_done = '0; t_rdy = '0; t_drv = '0;
        e_en = '0; e_oe = '0; e_we = '0; e_done = '0; e_rdy = '0; e_drv = '0;
        for (int c = 1; c <= wc + 3; c++) begin
            t_en[c] = en[i]; t_oe[c] = oe[i]; t_we[c] = wen[i];
            t_done[c] = done[i]; t_rdy[c] = ready[i]; t_drv[c] = drv(i);
            e_en[c]   = (c > wc + 2);
            e_oe[c]   = !(!w && c >= 2 && c <= wc + 1);
            e_we[c]   = !(w && c >= 2 && c <= wc + 1);
            e_done[c] = (c == wc + 2);
            e_rdy[c]  = (c == wc + 3);
            e_drv[c]  = w && (c <= wc + 2);
            if (c <= wc + 2 && raddr[i] !== a) bad_addr++;
            if (w && c <= wc + 2 && bus_val(i) !== d) bad_bus++;
            if (rdata[i] !== ((c < wc + 2) ? prev : exp_rd)) bad_rd++;
            if (c == 1) begin
                req[i]   = (mode == 2);
                we[i]    = (mode == 2) ? 1'b0 : 1'($urandom);
                addr[i]  = (mode == 2) ? next_a : AW'($urandom);
                wdata[i] = DW'($urandom);
            end
            if (mode == 1 && c == 2) begin
                req[i] = 1'b1; we[i] = ~w; addr[i] = ~a;
            end
            if (mode == 1 && c == 3) req[i] = 1'b0;
            if (c < wc + 3) step();
        end
        last_rd[i] = exp_rd;
        chk("en_trace",    32'(t_en),   32'(e_en));
        chk("oe_trace",    32'(t_oe),   32'(e_oe));
        chk("we_trace",    32'(t_we),   32'(e_we));
        chk("done_trace",  32'(t_done), 32'(e_done));
        chk("ready_trace", 32'(t_rdy),  32'(e_rdy));
        chk("drive_trace", 32'(t_drv),  32'(e_drv));
        chk("addr_held",   32'(bad_addr), 32'd0);
        chk("bus_data",    32'(bad_bus),  32'd0);
        chk("rdata",       32'(bad_rd),   32'd0);
    endtask

    typedef struct {
        int            inst;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            mode;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [10];
    logic [DW-1:0] model [2][16];

    initial begin
        int dn;
        tbl[0] = '{0, 1'b0, 18'h00012, 16'h0000, 0, 16'hBEEF};
        tbl[1] = '{1, 1'b1, 18'h3FFFF, 16'h1234, 0, 16'h0000};
        tbl[2] = '{1, 1'b0, 18'h3FFFF, 16'h0000, 0, 16'h1234};
        tbl[3] = '{0, 1'b1, 18'h00100, 16'hA5A5, 2, 16'hBEEF};
        tbl[4] = '{0, 1'b0, 18'h00100, 16'h0000, 0, 16'hA5A5};
        tbl[5] = '{1, 1'b0, 18'h00012, 16'h0000, 0, 16'h5A5A};
        tbl[6] = '{0, 1'b1, 18'h00000, 16'hFFFF, 1, 16'hA5A5};
        tbl[7] = '{0, 1'b0, 18'h00000, 16'h0000, 0, 16'hFFFF};
        tbl[8] = '{1, 1'b1, 18'h0ABCD, 16'h0F0F, 1, 16'h5A5A};
        tbl[9] = '{1, 1'b0, 18'h0ABCD, 16'h0000, 1, 16'h0F0F};

        // Asynchronous reset with the clock stopped.
        ctx = "reset";
        #3 rst = 1'b0;
        #1 reset_chk(0);
        reset_chk(1);
        #2 rst = 1'b1;
        clk_run = 1'b1;
        step();
        chk("ready_after_release", 32'(ready), 32'h3);

        preload(0, 18'h00012, 16'hBEEF);
        preload(1, 18'h00012, 16'h5A5A);
        step();

        for (int k = 0; k < 10; k++) begin
            ctx = $sformatf("vec%0d", k);
            run_txn(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].exp_rd,
                    tbl[k].mode, (k < 9) ? tbl[k+1].a : 18'h0);
        end
        ctx = "memory";
        chk("sram1_3ffff", 32'(sram1[18'h3FFFF]), 32'h1234);
        chk("sram0_00100", 32'(sram0[18'h00100]), 32'hA5A5);

        // Reset in the middle of a write strobe.
        ctx = "rst_mid_write";
        step();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 18'h0ABCD; wdata[1] = 16'h7777;
        step();
        req[1] = 1'b0;
        step();
        step();
        chk("we_low_before", 32'(wen[1]), 32'd0);
        #2 rst = 1'b0;
        #1 reset_chk(1);
        reset_chk(0);
        #2 rst = 1'b1;
        last_rd = '0;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            dn += int'(done[1]);
        end
        chk("no_done_after_reset", 32'(dn), 32'd0);
        chk("ready_idle", 32'(ready[1]), 32'd1);
        run_txn(1, 1'b0, 18'h00012, 16'h0, 16'h5A5A, 0, 18'h0);

        // Random traffic against an array model of each SRAM window.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) begin
                model[i][j] = DW'($urandom);
                preload(i, 18'h02000 + AW'(j), model[i][j]);
            end
            step();
            for (int n = 0; n < 30; n++) begin
                int j;
                logic w;
                logic [DW-1:0] d;
                j = int'($urandom_range(15, 0));
                w = 1'($urandom);
                d = DW'($urandom);
                ctx = $sformatf("rand%0d_%0d", i, n);
                run_txn(i, w, 18'h02000 + AW'(j), d, w ? last_rd[i] : model[i][j],
                        int'($urandom_range(1, 0)), 18'h0);
                if (w) model[i][j] = d;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
